// File: rtl/adder_measure_ctrl.sv
// ============================================================================
// adder_measure_ctrl : sequences operand setup, ring-oscillator run window,
// edge counting and result handshake for an instrumented adder.  Rev 1.0
// ============================================================================
`default_nettype none

module adder_measure_ctrl #(
  parameter int SYNC_STAGES   = 2,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic        wb_clk_i,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  input  logic [15:0] cmd_window,
  output logic [31:0] adder_a,
  output logic [31:0] adder_b,
  output logic        adder_ring_en,
  input  logic [31:0] adder_sum,
  input  logic        adder_chain_out,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_sum,
  output logic [31:0] rsp_count,
  output logic        rsp_overflow,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    RESP  = 3'd4
  } state_t;

  localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] DRAIN_LOAD  = 16'(SYNC_STAGES + 1);

  state_t                 state_q, state_d;
  logic [15:0]            timer_q, timer_d;
  logic [15:0]            window_q, window_d;
  logic [31:0]            a_q, a_d;
  logic [31:0]            b_q, b_d;
  logic                   ring_en_q, ring_en_d;
  logic                   cmd_ready_q, cmd_ready_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [31:0]            sum_q, sum_d;
  logic [31:0]            count_q, count_d;
  logic                   ovf_q, ovf_d;
  logic                   busy_q, busy_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   edge_q, edge_d;
  logic                   chain_rise;

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    window_d    = window_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    count_d     = count_q;
    ovf_d       = ovf_q;
    sync_d      = {sync_q[SYNC_STAGES-2:0], adder_chain_out};
    edge_d      = sync_q[SYNC_STAGES-1];
    chain_rise  = sync_q[SYNC_STAGES-1] & ~edge_q;

    // Edges still in the synchronizer when RUN ends are caught during DRAIN.
    if (chain_rise && (state_q == RUN || state_q == DRAIN)) begin
      if (count_q == 32'hFFFF_FFFF) begin
        ovf_d = 1'b1;
      end else begin
        count_d = count_q + 32'd1;
      end
    end

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          a_d      = cmd_a;
          b_d      = cmd_b;
          window_d = cmd_window;
          count_d  = 32'd0;
          ovf_d    = 1'b0;
          timer_d  = SETTLE_LOAD;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        if (timer_q == 16'd0) begin
          if (window_q == 16'd0) begin
            state_d = DRAIN;
            timer_d = DRAIN_LOAD;
          end else begin
            state_d = RUN;
            timer_d = window_q - 16'd1;
          end
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      RUN: begin
        if (timer_q == 16'd0) begin
          state_d = DRAIN;
          timer_d = DRAIN_LOAD;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      DRAIN: begin
        if (timer_q == 16'd0) begin
          sum_d   = adder_sum;
          state_d = RESP;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    ring_en_d   = (state_d == RUN);
    cmd_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge wb_clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      timer_q     <= 16'd0;
      window_q    <= 16'd0;
      a_q         <= 32'd0;
      b_q         <= 32'd0;
      ring_en_q   <= 1'b0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      sum_q       <= 32'd0;
      count_q     <= 32'd0;
      ovf_q       <= 1'b0;
      busy_q      <= 1'b0;
      sync_q      <= '0;
      edge_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      window_q    <= window_d;
      a_q         <= a_d;
      b_q         <= b_d;
      ring_en_q   <= ring_en_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      sum_q       <= sum_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      busy_q      <= busy_d;
      sync_q      <= sync_d;
      edge_q      <= edge_d;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign adder_a       = a_q;
  assign adder_b       = b_q;
  assign adder_ring_en = ring_en_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_sum       = sum_q;
  assign rsp_count     = count_q;
  assign rsp_overflow  = ovf_q;
  assign busy          = busy_q;

endmodule

`default_nettype wire
